// File: rtl/frame_scheduler.sv
// Per-frame sequencer owning the single frame-buffer port: CLEAR, then DRAW, then FLASH
// with the flasher's start/done/acknowledge handshake, paced by a free-running frame timer.
module frame_scheduler #(
   parameter int MEM_BITS    = 15,
   parameter int COLOR_W     = 3,
   parameter int MEM_DEPTH   = 19200,
   parameter int FRAME_TICKS = 833333
) (
   input  logic                Clck,
   input  logic                Reset,
   input  logic                enable,
   input  logic [COLOR_W-1:0]  bg_color,
   output logic                draw_go,
   input  logic                draw_done,
   input  logic [MEM_BITS-1:0] draw_addr,
   input  logic [COLOR_W-1:0]  draw_data,
   input  logic                draw_we,
   output logic                flash_go,
   input  logic                flash_done,
   output logic                flash_ack,
   input  logic [MEM_BITS-1:0] flash_addr,
   output logic [MEM_BITS-1:0] mem_addr,
   output logic [COLOR_W-1:0]  mem_wdata,
   output logic                mem_we,
   output logic                busy,
   output logic [15:0]         frame_count,
   output logic                overrun
);

   localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
   localparam logic [MEM_BITS-1:0] CLEAR_LAST = MEM_BITS'(MEM_DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      DRAW,
      FLASH,
      ACK
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [TICK_W-1:0]   tick_cnt;
   logic                tick_wrap;
   logic                pending;
   logic                start_frame;
   logic [MEM_BITS-1:0] clr_addr;
   logic [COLOR_W-1:0]  bg_latch;

   assign tick_wrap   = (tick_cnt == TICK_LAST);
   assign start_frame = (state == IDLE) && enable && pending;

   // A tick landing on the same edge a frame consumes the old one re-arms pending.
   always_ff @(posedge Clck) begin
      if (!Reset) begin
         tick_cnt <= '0;
         pending  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
         if (tick_wrap) begin
            pending <= 1'b1;
            if (pending && !start_frame) begin
               overrun <= 1'b1;
            end
         end else if (start_frame) begin
            pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge Clck) begin
      if (!Reset) begin
         state       <= IDLE;
         clr_addr    <= '0;
         bg_latch    <= '0;
         frame_count <= '0;
      end else begin
         state <= state_nx;
         if (start_frame) begin
            bg_latch <= bg_color;
            clr_addr <= '0;
         end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
         end
         if ((state == ACK) && !flash_done) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      draw_go   = 1'b0;
      flash_go  = 1'b0;
      flash_ack = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      busy      = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (start_frame) begin
               state_nx = CLEAR;
            end
         end
         CLEAR: begin
            mem_addr  = clr_addr;
            mem_wdata = bg_latch;
            mem_we    = 1'b1;
            if (clr_addr == CLEAR_LAST) begin
               state_nx = DRAW;
            end
         end
         DRAW: begin
            draw_go   = 1'b1;
            mem_addr  = draw_addr;
            mem_wdata = draw_data;
            mem_we    = draw_we;
            if (draw_done) begin
               state_nx = FLASH;
            end
         end
         FLASH: begin
            flash_go = 1'b1;
            mem_addr = flash_addr;
            if (flash_done) begin
               state_nx = ACK;
            end
         end
         ACK: begin
            flash_ack = 1'b1;
            if (!flash_done) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule
